// File: rtl/baud_tick_if.sv
// baud_tick_if: control/status bundle for baud_tick_gen
//   master: drives en, restart, inc_load, inc_in; observes the tick outputs
//   slave : the generator side (receives control, drives os_tick, bit_tick,
//           baud_clk, div_clk)
interface baud_tick_if #(
    parameter int ACC_W   = 24,
    parameter int NUM_DIV = 3
);
    logic               en;
    logic               restart;
    logic               inc_load;
    logic [ACC_W-1:0]   inc_in;
    logic               os_tick;
    logic               bit_tick;
    logic               baud_clk;
    logic [NUM_DIV-1:0] div_clk;

    modport master (
        output en, restart, inc_load, inc_in,
        input  os_tick, bit_tick, baud_clk, div_clk
    );

    modport slave (
        input  en, restart, inc_load, inc_in,
        output os_tick, bit_tick, baud_clk, div_clk
    );
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional phase-accumulator baud generator
//   clk, rst (async, active-high)
//   bus.en       advance accumulator / oversample counter
//   bus.restart  realign phase (clear acc and os_cnt)
//   bus.inc_load capture bus.inc_in as the new phase increment
//   bus.os_tick  pulse at baud*OVERSAMPLE; bus.bit_tick pulse once per bit
//   bus.baud_clk high for the first half of each bit
//   bus.div_clk  free-running clk/2 .. clk/2^NUM_DIV
module baud_tick_gen #(
    parameter int          ACC_W       = 24,
    parameter int          OVERSAMPLE  = 16,
    parameter int          NUM_DIV     = 3,
    parameter int unsigned DEFAULT_INC = 25770
) (
    input logic       clk,
    input logic       rst,
    baud_tick_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   inc_reg;
    logic [ACC_W:0]     sum;
    logic [CW-1:0]      os_cnt;
    logic [CW-1:0]      os_cnt_nx;
    logic [NUM_DIV-1:0] div_cnt;
    logic               os_tick;
    logic               baud_clk;
    logic               adv;

    // Carry out of the ACC_W+1 bit add is the raw oversample event.
    always_comb begin
        adv       = bus.en & ~bus.restart;
        sum       = {1'b0, acc} + {1'b0, inc_reg};
        os_cnt_nx = bus.restart ? '0 :
                    !os_tick ? os_cnt :
                    (os_cnt == CW'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            inc_reg  <= ACC_W'(DEFAULT_INC);
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            baud_clk <= 1'b0;
            div_cnt  <= '0;
        end else begin
            if (bus.inc_load)
                inc_reg <= bus.inc_in;
            if (bus.restart)
                acc <= '0;
            else if (bus.en)
                acc <= sum[ACC_W-1:0];
            os_tick  <= adv & sum[ACC_W];
            os_cnt   <= os_cnt_nx;
            // Registered from the next count so it lines up with os_cnt.
            baud_clk <= os_cnt_nx < CW'(OVERSAMPLE / 2);
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    assign bus.os_tick  = os_tick;
    assign bus.bit_tick = os_tick & (os_cnt == CW'(OVERSAMPLE - 1));
    assign bus.baud_clk = baud_clk;
    assign bus.div_clk  = div_cnt;
endmodule
